// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory and buffers results in a 2-entry queue.
// Optional redirect alignment checking is enabled with `define INST_FETCH_ALIGN_CHECK_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned IMEM_AW  = 11,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_inst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [31:0]        id_inst,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic               misalign_err,
  output logic [31:0]        err_pc
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [31:0] inst_q [2];
  logic [31:0] epc_q  [2];
  logic        pop, push, tail;

  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign id_valid  = (count_q != 2'd0);
  assign pop       = id_valid & id_ready;
  assign push      = fetch_en & ~redirect_valid & ((count_q < 2'(QDEPTH)) | pop);
  // Tail slot is head when empty or full, the other slot when holding one entry.
  assign tail      = head_q ^ count_q[0];

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    head_d  = head_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      if (push) pc_d = pc_q + 32'd4;
      if (pop)  head_d = ~head_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q[0] <= 32'h0;
      inst_q[1] <= 32'h0;
      epc_q[0]  <= 32'h0;
      epc_q[1]  <= 32'h0;
    end else if (push) begin
      inst_q[tail] <= imem_inst;
      epc_q[tail]  <= pc_q;
    end
  end

  // Empty queue presents a NOP with zeroed PCs.
  assign id_inst = id_valid ? inst_q[head_q] : 32'h0;
  assign id_pc   = id_valid ? epc_q[head_q] : 32'h0;
  assign id_pc4  = id_valid ? epc_q[head_q] + 32'd4 : 32'h0;

`ifdef INST_FETCH_ALIGN_CHECK_EN
  logic        mis_q;
  logic [31:0] err_q;
  logic        mis_now;

  assign mis_now = redirect_valid & (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
      err_q <= 32'h0;
    end else begin
      mis_q <= mis_now;
      if (mis_now) err_q <= redirect_pc;
    end
  end

  assign misalign_err = mis_q;
  assign err_pc       = err_q;
`else
  logic unused_rpc_lo;
  assign unused_rpc_lo = ^redirect_pc[1:0];
  assign misalign_err  = 1'b0;
  assign err_pc        = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit against a queue-level fetch model.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic [10:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic        misalign_err;
  logic [31:0] err_pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory word k holds 0x1000_0000 + k.
  assign imem_inst = 32'h1000_0000 + {21'b0, imem_addr};

  inst_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_AW(11), .QDEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
    .id_pc4        (id_pc4),
    .misalign_err  (misalign_err),
    .err_pc        (err_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] mpc;
  logic        exp_mis;
  logic [31:0] exp_err;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) % 32'd2048);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: fetch PC plus a FIFO of fetched {pc, inst}, at most two deep.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      mpc     = RESET_PC;
      exp_mis = 1'b0;
      exp_err = 32'h0;
    end else begin
`ifdef INST_FETCH_ALIGN_CHECK_EN
      exp_mis = redirect_valid && (redirect_pc % 4 != 0);
      if (exp_mis) exp_err = redirect_pc;
`endif
      if (redirect_valid) begin
        sb.delete();
        mpc = redirect_pc - (redirect_pc % 4);
      end else if (fetch_en && sb.size() < 2) begin
        // Monitor already removed an entry accepted at this edge.
        sb.push_back(ent_t'{pc: mpc, inst: mem_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  end

  // Monitor: compares the presented head and retires it on a handshake.
  always @(negedge clk) begin
    chk("imem_addr", {21'b0, imem_addr}, (mpc >> 2) % 32'd2048);
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
    chk("err_pc", err_pc, exp_err);
    if (sb.size() == 0) begin
      chk("id_valid_empty", {31'b0, id_valid}, 32'd0);
      chk("id_inst_empty", id_inst, 32'h0);
      chk("id_pc_empty", id_pc, 32'h0);
      chk("id_pc4_empty", id_pc4, 32'h0);
    end else begin
      chk("id_valid", {31'b0, id_valid}, 32'd1);
      chk("id_pc", id_pc, sb[0].pc);
      chk("id_inst", id_inst, sb[0].inst);
      chk("id_pc4", id_pc4, sb[0].pc + 32'd4);
      if (rst_n && id_ready && !redirect_valid) void'(sb.pop_front());
    end
  end

  task automatic step(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    fetch_en       = fe;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  initial begin
    #2;
    chk("reset_id_valid", {31'b0, id_valid}, 32'd0);
    chk("reset_imem_addr", {21'b0, imem_addr}, 32'd0);
    chk("reset_err_pc", err_pc, 32'h0);
    fetch_en = 1'b1;
    id_ready = 1'b1;
    #10 rst_n = 1'b1;

    // Streaming fill and one-per-cycle throughput.
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Backpressure from a fresh start at RESET_PC.
    step(1'b1, 1'b1, 1'b1, RESET_PC);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("bp_imem_addr", {21'b0, imem_addr}, 32'd2);
    chk("bp_head", id_pc, RESET_PC);
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect while full and accepting.
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0040_0100);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Memory wrap and full 32-bit PC wrap.
    step(1'b1, 1'b1, 1'b1, 32'h0040_1FFC);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);

    // fetch_en gap: PC holds, queue drains.
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect.
    step(1'b1, 1'b1, 1'b1, 32'h0040_0106);
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset between edges while full.
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("async_rst_misalign", {31'b0, misalign_err}, 32'd0);
    chk("async_rst_imem_addr", {21'b0, imem_addr}, 32'd0);
    #3 rst_n = 1'b1;
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        fe, rdy, rv;
      logic [31:0] rpc;
      fe  = ($urandom_range(0, 9) < 8);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
      step(fe, rdy, rv, rpc);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction memory wrapper in the 54-instruction MIPS CPU.
- Owns the PC and drives the 11-bit word address into the asynchronous-read instruction memory. Captures the returned 32-bit instruction into a 2-entry fetch queue.
- Presents the queue head to decode with a valid/ready handshake. Handles branch/jump redirects with a queue flush.

Parameters:
- RESET_PC, 32'h0040_0000: PC value loaded on reset.
- IMEM_AW, 11: instruction memory word-address width.
- QDEPTH, 2: fetch queue depth; only 2 is supported.

Ports:
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous active-low reset.
- fetch_en  input  1: when low, no new fetch is pushed; queue still drains.
- imem_addr  output  IMEM_AW: word address to instruction memory, pc_q[IMEM_AW+1:2].
- imem_inst  input  32: instruction data from memory, valid in the same cycle as imem_addr.
- redirect_valid  input  1: branch/jump/exception redirect request.
- redirect_pc  input  32: redirect target.
- id_valid  output  1: queue head valid.
- id_ready  input  1: decode accepts the head this cycle.
- id_inst  output  32: head instruction.
- id_pc  output  32: head PC.
- id_pc4  output  32: head PC + 4.
- misalign_err  output  1: misaligned redirect pulse (see Optional Feature).
- err_pc  output  32: offending redirect target (see Optional Feature).

Behaviour:
- Reset (asynchronous, any time, including mid-flush):
  - pc_q = RESET_PC; queue count = 0.
  - id_valid = 0; id_inst = 32'h0; id_pc = 0; id_pc4 = 0.
  - misalign_err = 0; err_pc = 0.
- imem_addr is combinational from pc_q. Upper PC bits above IMEM_AW+1 are dropped, so addresses wrap modulo 2^IMEM_AW words.
- pop = id_valid & id_ready.
- push = fetch_en & ~redirect_valid & (count < 2 | pop).
  - On push: {imem_inst, pc_q} is written to the queue tail and pc_q <= pc_q + 4.
  - pc_q wraps 32'hFFFF_FFFC -> 0.
- Simultaneous push and pop with count = 2: allowed; count stays 2.
- Simultaneous push and pop with count = 1: the head advances to the new entry.
- Simultaneous push and pop with count = 0: not possible (id_valid = 0).
- Queue storage is two registered entries with a head pointer. Outputs come directly from the head entry, with no combinational path from imem_inst to id_*.
- When count = 0, id_inst = 0 (NOP), id_pc = 0 and id_pc4 = 0.
- Redirect has highest priority and overrides push and pop:
  - Next cycle: count = 0, id_valid = 0, pc_q = {redirect_pc[31:2], 2'b00}.
  - The following cycle: the target instruction is fetched.
  - Minimum redirect-to-id_valid latency is 2 cycles.
- id_ready while id_valid = 0 is ignored.
- fetch_en low: pc_q holds and the queue drains normally. fetch_en re-asserted: fetch resumes at the held pc_q with no skipped or duplicated PC.
- Throughput: with id_ready held high and no redirects, one instruction per cycle after the first fill. The first id_valid appears 1 cycle after reset release.
- Head ordering: strict FIFO. Each PC appears at id_pc exactly once between redirects.

Optional Feature:
- Macro: INST_FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 drives misalign_err high for exactly one cycle, the cycle after the redirect.
  - The same redirect loads err_pc <= redirect_pc; err_pc holds until the next misaligned redirect or reset.
  - The queue is flushed and pc_q loads the aligned target as normal.
- Not defined: misalign_err is tied 0, err_pc is tied 0, and low bits are silently discarded.

Test Plan:
- Reset release, fetch_en = 1, id_ready = 1, memory word k = 32'h1000_0000+k:
  - id_pc sequence is 0x00400000, 0x00400004, 0x00400008…
  - id_inst sequence is 0x10000000, 0x10000001…
  - one per cycle; imem_addr 0,1,2…
- Backpressure: id_ready = 0 for 5 cycles after the first fetch:
  - count saturates at 2 and pc_q stops at 0x00400008.
  - On release, heads 0x00400000 and 0x00400004 appear, then 0x00400008 follows with no gap or duplicate.
- Redirect to 0x00400100 while count = 2 and id_ready = 1 in the same cycle:
  - next cycle id_valid = 0;
  - the cycle after, id_pc = 0x00400100 and id_inst = memory word 0x40.
- Wrap boundary: redirect to 0x00401FFC (word 0x7FF):
  - imem_addr 0x7FF then 0x000;
  - id_pc 0x00401FFC then 0x00402000.
- Mid-operation reset: assert rst_n = 0 asynchronously between clock edges while count = 2:
  - id_valid, count and misalign_err are immediately 0;
  - after release, id_pc = 0x00400000.
- With INST_FETCH_ALIGN_CHECK_EN: redirect_pc = 0x00400106:
  - misalign_err = 1 for one cycle and err_pc = 0x00400106;
  - the next id_pc = 0x00400104.
  - Without the macro: misalign_err stays 0.
